// File: rtl/cv32e40p_obi_resp_mem.sv
// Data-side OBI responder: byte-enable word RAM, LFSR-driven grant stalls, in-order responses with run-time latency.
// Define CV32E40P_OBI_RESP_ERR_EN to add err_o and reject addresses above the decoded range.
module cv32e40p_obi_resp_mem #(
    parameter int unsigned ADDR_WIDTH      = 16,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 req_i,
    output logic                                 gnt_o,
    input  logic [31:0]                          addr_i,
    input  logic                                 we_i,
    input  logic [3:0]                           be_i,
    input  logic [31:0]                          wdata_i,
    output logic                                 rvalid_o,
    output logic [31:0]                          rdata_o,
    input  logic                                 cfg_stall_en_i,
    input  logic [3:0]                           cfg_lat_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
`ifdef CV32E40P_OBI_RESP_ERR_EN
    ,
    output logic                                 err_o
`endif
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned WORDS = 2 ** (ADDR_WIDTH - 2);

    logic [31:0]           mem    [WORDS];
    logic [31:0]           q_data [MAX_OUTSTANDING];
    logic                  q_err  [MAX_OUTSTANDING];
    logic [15:0]           lfsr_q;
    logic [CNT_W-1:0]      count_q, remain, count_nxt;
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q, rd_ptr_nxt;
    logic [3:0]            wait_q, wait_nxt;
    logic                  rvalid_q, rvalid_nxt, err_q;
    logic [31:0]           rdata_q, head_data, push_data;
    logic                  head_err, addr_err, stall, full, push, pop;
    logic [ADDR_WIDTH-3:0] word_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef CV32E40P_OBI_RESP_ERR_EN
    logic unused_addr;
    assign addr_err    = |addr_i[31:ADDR_WIDTH];
    assign err_o       = err_q;
    assign unused_addr = ^addr_i[1:0];
`else
    logic unused_bits;
    assign addr_err    = 1'b0;
    assign unused_bits = ^{addr_i[31:ADDR_WIDTH], addr_i[1:0], err_q};
`endif

    // No pop-to-grant path: full is judged on the registered count only.
    assign stall      = cfg_stall_en_i && lfsr_q[0];
    assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign gnt_o      = req_i && !full && !stall;
    assign push       = gnt_o;
    assign pop        = rvalid_q;
    assign word_idx   = addr_i[ADDR_WIDTH-1:2];
    assign push_data  = (we_i || addr_err) ? 32'h0 : mem[word_idx];
    assign remain     = count_q - CNT_W'(pop);
    assign count_nxt  = remain + CNT_W'(push);
    assign rd_ptr_nxt = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Work out next cycle's head so rvalid_o/rdata_o can be registered yet still
    // appear one cycle after a grant into an empty queue.
    always_comb begin
        head_data = q_data[rd_ptr_nxt];
        head_err  = q_err[rd_ptr_nxt];
        wait_nxt  = wait_q;
        if (remain == '0) begin
            wait_nxt = 4'd0;
            if (push) begin
                head_data = push_data;
                head_err  = addr_err;
                wait_nxt  = cfg_lat_i;
            end
        end else if (pop) begin
            wait_nxt = cfg_lat_i;
        end else if (wait_q != 4'd0) begin
            wait_nxt = wait_q - 4'd1;
        end
        rvalid_nxt = (count_nxt != '0) && (wait_nxt == 4'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q   <= LFSR_SEED;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            wait_q   <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            lfsr_q   <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            count_q  <= count_nxt;
            rd_ptr_q <= rd_ptr_nxt;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            wait_q   <= wait_nxt;
            rvalid_q <= rvalid_nxt;
            err_q    <= rvalid_nxt && head_err;
            if (rvalid_nxt) begin
                rdata_q <= head_data;
            end
        end
    end

    // Storage is not reset; RAM writes survive a mid-flight reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_data[wr_ptr_q] <= push_data;
            q_err[wr_ptr_q]  <= addr_err;
        end
        if (push && we_i && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rvalid_o      = rvalid_q;
    assign rdata_o       = rdata_q;
    assign outstanding_o = count_q;

endmodule

// File: doc/cv32e40p_obi_resp_mem.md
Name: cv32e40p_obi_resp_mem

Overview:
- Data-side OBI responder for the core's data port (data_req/gnt/rvalid): the memory end of the bus the core initiates.
- Word-addressed RAM with byte-enable writes and in-order responses.
- Grant stalls (LFSR-driven) and response latency are configurable at run time, so testbenches can stress the core's load/store unit under non-ideal bus timing.
- Instantiated beside the core in place of, or alongside, the zero-wait memory.

Parameters:
- ADDR_WIDTH, 16, byte-address bits decoded; RAM holds 2**(ADDR_WIDTH-2) words.
- MAX_OUTSTANDING, 2, depth of response queue (>=1).
- LFSR_SEED, 16'hACE1, reset value of the stall LFSR (must be nonzero).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- gnt_o  out  1  request accepted (combinational)
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1 = write
- be_i  in  4  byte enables
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one per granted request
- rdata_o  out  32  read data; 0 for writes
- cfg_stall_en_i  in  1  enable LFSR-driven grant stalls
- cfg_lat_i  in  4  extra response wait cycles, 0..15
- outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  granted requests not yet responded

Behaviour:
- Clock and reset: one clock, clk_i. Reset on rst_ni is asynchronous and active-low.
- Reset values:
  - rvalid_o=0, rdata_o=0, outstanding_o=0.
  - Queue empty, head wait counter 0, LFSR=LFSR_SEED.
  - RAM contents are not reset.
- Handshake: a transfer occurs when req_i && gnt_o. The initiator holds addr/we/be/wdata stable until gnt_o. rvalid_o has no back-pressure.
- Grant: gnt_o = req_i && !full && !stall.
  - full means outstanding == MAX_OUTSTANDING.
  - A pop in the same cycle does not free a slot for grant (no pop-to-gnt combinational path).
- Stall:
  - stall = cfg_stall_en_i && lfsr[0].
  - LFSR is 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every cycle regardless of req_i.
- Memory access happens in the grant cycle:
  - Write: updates bytes whose be_i bit is set, at word addr_i[ADDR_WIDTH-1:2].
  - Read: captures the word in the same cycle.
  - This enforces program order: a read granted after a write sees the written data.
- Queue: FIFO of {rdata} entries, push on grant. Write entries carry rdata=0.
- Latency:
  - A head wait counter is loaded with cfg_lat_i when an entry becomes head, either by push into an empty queue or by pop of its predecessor. It then decrements to 0.
  - rvalid_o=1 in any cycle where the head exists and the counter is 0. rdata_o=head data; the head is popped that cycle.
  - Empty-queue latency: grant at cycle T gives rvalid at T+1+cfg_lat_i. rvalid never coincides with the grant cycle of the same request.
- Registered outputs: rvalid_o and rdata_o are registered. When rvalid_o=0, rdata_o holds its last value.
- Simultaneous push and pop: allowed; outstanding_o unchanged.
- Queue pointers: wrap modulo MAX_OUTSTANDING.
- cfg_lat_i changes: a change applies only to entries that become head afterwards.
- Reset mid-operation: all pending responses are dropped and no rvalid is issued for them. RAM writes already performed persist.

Optional Feature:
- Macro: CV32E40P_OBI_RESP_ERR_EN.
- Defined:
  - Adds output port err_o (1 bit), registered and aligned with rvalid_o.
  - A request with addr_i[31:ADDR_WIDTH] != 0 is still granted, but performs no RAM access.
  - Its response has err_o=1 and rdata_o=0. err_o=0 otherwise and at reset.
- Not defined: no err_o port; upper address bits are ignored, so accesses alias modulo RAM size.

Test Plan:
- Read, zero latency: cfg_lat_i=0, stall off, RAM[0x10]=0xDEADBEEF, read 0x40 granted at T -> gnt_o=1 at T, rvalid_o=1 at T+1, rdata_o=0xDEADBEEF.
- Configured latency: cfg_lat_i=3, read granted at T -> rvalid_o first high at T+4; outstanding_o=1 over T+1..T+4, 0 at T+5.
- Byte-enable write then read: write 0x11223344 be=4'b1111, then 0xAABBCCDD be=4'b0101 to 0x80, then read 0x80 -> responses rdata 0, 0, then 0x11BB33DD, in order.
- Queue full: MAX_OUTSTANDING=2, cfg_lat_i=5, req_i held high with 3 reads -> first two granted on consecutive cycles; third not granted until the cycle after the first rvalid; rvalids in request order.
- Stall: cfg_stall_en_i=1, 64 back-to-back reads -> gnt_o pattern equals !lfsr[0] from seed 0xACE1; every grant matched by exactly one rvalid; no data corruption.
- Reset mid-flight: cfg_lat_i=8, two reads granted, rst_ni low 1 cycle -> rvalid_o never asserts for them; outstanding_o=0. With the feature macro: a read to 0x8000_0000 gives err_o=1, rdata_o=0.
